// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor: adds a WIDTH-bit operand pair CHUNK bits per clock,
// carrying between chunks in a register, with a start/busy/done handshake.
module chunked_serial_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] opa, opb, shadow, shadow_nx;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [CHUNK:0]   csum;
  logic             accept, last;
  int unsigned      base;

  always_comb begin
    accept    = start && (state != RUN);
    last      = (state == RUN) && (cnt == LAST);
    base      = 32'(cnt) * CHUNK;
    csum      = {1'b0, opa[base +: CHUNK]} + {1'b0, opb[base +: CHUNK]}
              + {{CHUNK{1'b0}}, carry};
    // Completion needs the final chunk merged in the same cycle it is computed.
    shadow_nx = shadow;
    shadow_nx[base +: CHUNK] = csum[CHUNK-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opa      <= '0;
      opb      <= '0;
      shadow   <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        opa   <= a;
        opb   <= sub ? ~b : b;
        carry <= sub ? 1'b1 : cin;
        cnt   <= '0;
        busy  <= 1'b1;
      end else if (state == RUN) begin
        shadow <= shadow_nx;
        carry  <= csum[CHUNK];
        cnt    <= cnt + 1'b1;
        if (last) begin
          sum      <= shadow_nx;
          cout     <= csum[CHUNK];
          overflow <= (opa[WIDTH-1] == opb[WIDTH-1]) &&
                      (shadow_nx[WIDTH-1] != opa[WIDTH-1]);
          busy     <= 1'b0;
          done     <= 1'b1;
          cnt      <= '0;
        end
      end
    end
  end

endmodule

// File: doc/chunked_serial_adder.md
Name: chunked_serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor. It processes a WIDTH-bit operand pair CHUNK bits per clock and keeps the carry in a register between chunks.
- Successor to the combinational 8-bit ripple adder. It adds operand width and chunk-size generalisation, a subtract mode, signed-overflow detection and a start/busy/done handshake.
- Used wherever area matters more than latency, and as a shared arithmetic unit behind a simple controller.

Parameters:
- WIDTH, 8, operand and sum width in bits. Must be ≥1 and an integer multiple of CHUNK.
- CHUNK, 2, bits added per clock cycle. Must satisfy 1 ≤ CHUNK ≤ WIDTH.
- NCHUNK is a derived localparam equal to WIDTH/CHUNK. It sets the number of processing cycles.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled at the rising edge of clk.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0 selects a+b+cin; 1 selects a−b, computed as a+~b+1 with cin ignored.
- sum  output  WIDTH  result; registered and updated only when an operation completes.
- cout  output  1  final carry-out. In subtract mode, 1 means no borrow (a ≥ b unsigned).
- overflow  output  1  two's-complement signed overflow of the completed operation.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when sum, cout and overflow become valid.

Behaviour:
- Reset: when rst=1 at a clock edge, the block enters IDLE. sum, cout, overflow, busy and done are all cleared to 0, and the internal chunk counter, carry and operand registers are cleared to 0. rst takes priority over every other input.
- States:
  - IDLE → RUN on start=1.
  - RUN → DONE after NCHUNK chunk cycles.
  - DONE → IDLE if start=0.
  - DONE → RUN if start=1 (back-to-back operation accepted).
- Accept edge (start=1 while in IDLE or DONE), call it edge k:
  - latch a into opA;
  - latch b into opB when sub=0, or ~b when sub=1;
  - load carry with cin when sub=0, or 1 when sub=1;
  - set the counter to 0;
  - busy←1, done←0.
- Accepted operands are held internally, so a, b, cin and sub may change freely after the accept edge.
- start while in RUN is ignored. There is no queueing and no effect on the operation in flight.
- RUN, edges k+1 to k+NCHUNK: on each edge, add chunk i = counter of opA and opB plus carry.
  - Write the CHUNK-bit chunk result into the shadow sum at bits [i·CHUNK+CHUNK−1 : i·CHUNK].
  - The chunk carry-out becomes the new carry, and the counter increments.
  - Chunk 0 holds the least significant bits.
- Completion, edge k+NCHUNK:
  - sum ← full shadow result; cout ← final carry.
  - overflow ← (opA[MSB] == opB[MSB]) and (sum[MSB] != opA[MSB]), using the post-inversion opB.
  - busy←0, done←1.
- Latency: done is high during the cycle after edge k+NCHUNK. That is NCHUNK cycles after the accept edge, so throughput is one operation per NCHUNK+1 cycles in the worst case.
- done is high for exactly one cycle and is cleared at the next edge.
- Output stability: sum, cout and overflow keep their last completed values through IDLE and through any subsequent RUN, until the next completion. They never show partial results.
- Reset mid-operation: the operation is aborted and all outputs are cleared per the reset rule; no done pulse is produced.
- start asserted on the same edge as rst: rst wins, and the block sits in IDLE afterwards.
- Degenerate case CHUNK=WIDTH: a single RUN cycle, with done high during the cycle after edge k+1.
- Width rules: every chunk add is CHUNK+1 bits wide. There is no truncation of the carry, and the result is exact modulo 2^WIDTH, with cout as bit WIDTH.

Test Plan:
- WIDTH=8, CHUNK=2, add: a=0x3C, b=0x45, cin=0, sub=0, start pulsed → busy high for 4 cycles; done pulses 4 cycles after the accept edge; sum=0x81, cout=0, overflow=1.
- Add with carry: a=0xFF, b=0x01, cin=1 → sum=0x01, cout=1, overflow=0. The carry must propagate through all 4 chunks.
- Subtract:
  - a=0x05, b=0x07, sub=1, cin=1 (ignored) → sum=0xFE, cout=0, overflow=0.
  - Then back-to-back, start held in the DONE cycle: a=0x80, b=0x01, sub=1 → sum=0x7F, cout=1, overflow=1.
- Handshake and reset:
  - start re-pulsed mid-RUN → result and timing unchanged.
  - Operands changed after accept → no effect on the result.
  - rst=1 at the second RUN edge → all outputs 0, no done pulse, and the next start works normally.
- Exhaustive: all 256×256 operand pairs × cin∈{0,1} × sub∈{0,1}, checked against a reference model of a+b+cin or a+~b+1 (9-bit result).
- Parameter sweep: repeat the exhaustive check for CHUNK∈{1,4,8}, and run random-operand checks for WIDTH=16 with CHUNK=4 and for WIDTH=32 with CHUNK=8. Verify that done latency equals NCHUNK in every configuration.
